// File: rtl/prf_tagged_rf.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : prf_tagged_rf
// Brief    : Tagged physical register file (data / busy / producer ROB ID)
//            with N_ALLOC allocation ports, N_WB writeback ports and N_RD
//            registered read ports. Each read port has its own stall-hold,
//            and a full-pipeline flush clears busy bits and responses.
// Options  : PRF_WB_BYPASS_EN -- when defined, new responses see the
//            same-edge alloc/writeback/flush result and held responses are
//            patched in place by matching writebacks. When undefined,
//            responses show pre-edge array state and held responses stay
//            frozen apart from the flush clear.
// Revision : 1.0 - initial release
// ============================================================================
module prf_tagged_rf #(
  parameter int NUM_PREGS = 64,
  parameter int DATA_W    = 32,
  parameter int ROB_W     = 5,
  parameter int N_ALLOC   = 2,
  parameter int N_WB      = 2,
  parameter int N_RD      = 6,
  parameter int PREG_W    = $clog2(NUM_PREGS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_ALLOC-1:0]               alloc_valid,
  input  logic [N_ALLOC-1:0][PREG_W-1:0]   alloc_preg,
  input  logic [N_ALLOC-1:0][ROB_W-1:0]    alloc_rob,
  input  logic [N_WB-1:0]                  wb_valid,
  input  logic [N_WB-1:0][PREG_W-1:0]      wb_preg,
  input  logic [N_WB-1:0][DATA_W-1:0]      wb_data,
  input  logic                             flush,
  input  logic [N_RD-1:0]                  rd_valid,
  input  logic [N_RD-1:0][PREG_W-1:0]      rd_preg,
  input  logic [N_RD-1:0]                  rd_stall,
  output logic [N_RD-1:0]                  rsp_valid,
  output logic [N_RD-1:0][DATA_W-1:0]      rsp_data,
  output logic [N_RD-1:0]                  rsp_busy,
  output logic [N_RD-1:0][ROB_W-1:0]       rsp_rob
);

  // Register array state
  logic [DATA_W-1:0]    data_q [NUM_PREGS];
  logic [DATA_W-1:0]    data_d [NUM_PREGS];
  logic [ROB_W-1:0]     rob_q  [NUM_PREGS];
  logic [ROB_W-1:0]     rob_d  [NUM_PREGS];
  logic [NUM_PREGS-1:0] busy_q;
  logic [NUM_PREGS-1:0] busy_d;

  // Read-source values chosen per port before they enter the response flops
  logic [N_RD-1:0][DATA_W-1:0] src_data;
  logic [N_RD-1:0]             src_busy;
  logic [N_RD-1:0][ROB_W-1:0]  src_rob;

  // Response registers
  logic [N_RD-1:0]             rsp_valid_q, rsp_valid_d;
  logic [N_RD-1:0][DATA_W-1:0] rsp_data_q,  rsp_data_d;
  logic [N_RD-1:0]             rsp_busy_q,  rsp_busy_d;
  logic [N_RD-1:0][ROB_W-1:0]  rsp_rob_q,   rsp_rob_d;
`ifdef PRF_WB_BYPASS_EN
  // Which preg each held response came from, so writebacks can patch it
  logic [N_RD-1:0][PREG_W-1:0] rsp_preg_q,  rsp_preg_d;
`endif

  // Next array state: writebacks first, then flush or allocations on top.
  // Ports are walked high-to-low so the lowest index lands last and wins.
  always_comb begin
    data_d = data_q;
    rob_d  = rob_q;
    busy_d = busy_q;
    for (int p = N_WB - 1; p >= 0; p--) begin
      if (wb_valid[p] && (wb_preg[p] != '0)) begin
        data_d[wb_preg[p]] = wb_data[p];
        busy_d[wb_preg[p]] = 1'b0;
      end
    end
    if (flush) begin
      busy_d = '0;
    end else begin
      for (int p = N_ALLOC - 1; p >= 0; p--) begin
        if (alloc_valid[p] && (alloc_preg[p] != '0)) begin
          busy_d[alloc_preg[p]] = 1'b1;
          rob_d[alloc_preg[p]]  = alloc_rob[p];
        end
      end
    end
  end

  // Per-port read source: post-edge state with bypass, pre-edge without.
  // Preg 0 is masked here so it always reads as an idle zero.
  always_comb begin
    src_data = '0;
    src_busy = '0;
    src_rob  = '0;
    for (int i = 0; i < N_RD; i++) begin
      if (rd_preg[i] != '0) begin
`ifdef PRF_WB_BYPASS_EN
        src_data[i] = data_d[rd_preg[i]];
        src_busy[i] = busy_d[rd_preg[i]];
        src_rob[i]  = rob_d[rd_preg[i]];
`else
        src_data[i] = data_q[rd_preg[i]];
        src_busy[i] = busy_q[rd_preg[i]];
        src_rob[i]  = rob_q[rd_preg[i]];
`endif
      end
    end
  end

  // Response next state: load when not stalled, hold (and optionally patch)
  // when stalled; flush always drops the valid bit.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_busy_d  = rsp_busy_q;
    rsp_rob_d   = rsp_rob_q;
`ifdef PRF_WB_BYPASS_EN
    rsp_preg_d  = rsp_preg_q;
`endif
    for (int i = 0; i < N_RD; i++) begin
      if (!rd_stall[i]) begin
        rsp_valid_d[i] = rd_valid[i];
        if (rd_valid[i]) begin
          rsp_data_d[i] = src_data[i];
          rsp_busy_d[i] = src_busy[i];
          rsp_rob_d[i]  = src_rob[i];
`ifdef PRF_WB_BYPASS_EN
          rsp_preg_d[i] = rd_preg[i];
`endif
        end
      end
`ifdef PRF_WB_BYPASS_EN
      else begin
        for (int p = N_WB - 1; p >= 0; p--) begin
          if (wb_valid[p] && (rsp_preg_q[i] != '0) && (wb_preg[p] == rsp_preg_q[i])) begin
            rsp_data_d[i] = wb_data[p];
            rsp_busy_d[i] = 1'b0;
          end
        end
      end
`endif
      if (flush) begin
        rsp_valid_d[i] = 1'b0;
      end
    end
  end

  // Array state flops; reset clears everything
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '{default: '0};
      rob_q  <= '{default: '0};
      busy_q <= '0;
    end else begin
      data_q <= data_d;
      rob_q  <= rob_d;
      busy_q <= busy_d;
    end
  end

  // Response flops; reset has priority over flush and stall
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_busy_q  <= '0;
      rsp_rob_q   <= '0;
`ifdef PRF_WB_BYPASS_EN
      rsp_preg_q  <= '0;
`endif
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_busy_q  <= rsp_busy_d;
      rsp_rob_q   <= rsp_rob_d;
`ifdef PRF_WB_BYPASS_EN
      rsp_preg_q  <= rsp_preg_d;
`endif
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_busy  = rsp_busy_q;
  assign rsp_rob   = rsp_rob_q;

endmodule
`default_nettype wire

// File: tb/tb_prf_tagged_rf.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_prf_tagged_rf
// Brief    : Directed scoreboard bench for prf_tagged_rf. Stimulus pushes the
//            expected response for the next edge; a monitor pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prf_tagged_rf;

  localparam int NUM_PREGS = 64;
  localparam int DATA_W    = 32;
  localparam int ROB_W     = 5;
  localparam int N_ALLOC   = 2;
  localparam int N_WB      = 2;
  localparam int N_RD      = 6;
  localparam int PREG_W    = $clog2(NUM_PREGS);
`ifdef PRF_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [N_ALLOC-1:0]             alloc_valid;
  logic [N_ALLOC-1:0][PREG_W-1:0] alloc_preg;
  logic [N_ALLOC-1:0][ROB_W-1:0]  alloc_rob;
  logic [N_WB-1:0]                wb_valid;
  logic [N_WB-1:0][PREG_W-1:0]    wb_preg;
  logic [N_WB-1:0][DATA_W-1:0]    wb_data;
  logic                           flush;
  logic [N_RD-1:0]                rd_valid;
  logic [N_RD-1:0][PREG_W-1:0]    rd_preg;
  logic [N_RD-1:0]                rd_stall;
  logic [N_RD-1:0]                rsp_valid;
  logic [N_RD-1:0][DATA_W-1:0]    rsp_data;
  logic [N_RD-1:0]                rsp_busy;
  logic [N_RD-1:0][ROB_W-1:0]     rsp_rob;

  always #5 clk = ~clk;

  prf_tagged_rf #(
    .NUM_PREGS (NUM_PREGS),
    .DATA_W    (DATA_W),
    .ROB_W     (ROB_W),
    .N_ALLOC   (N_ALLOC),
    .N_WB      (N_WB),
    .N_RD      (N_RD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .alloc_valid (alloc_valid),
    .alloc_preg  (alloc_preg),
    .alloc_rob   (alloc_rob),
    .wb_valid    (wb_valid),
    .wb_preg     (wb_preg),
    .wb_data     (wb_data),
    .flush       (flush),
    .rd_valid    (rd_valid),
    .rd_preg     (rd_preg),
    .rd_stall    (rd_stall),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_busy    (rsp_busy),
    .rsp_rob     (rsp_rob)
  );

  typedef struct {
    int                tgt;
    int                port;
    bit                chk_all;
    bit                v;
    logic [DATA_W-1:0] d;
    bit                b;
    logic [ROB_W-1:0]  r;
    string             name;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic push_exp(input int port, input bit chk_all, input bit v,
                          input logic [DATA_W-1:0] d, input bit b,
                          input logic [ROB_W-1:0] r, input string name);
    exp_t e;
    e.tgt = cyc + 1; e.port = port; e.chk_all = chk_all;
    e.v = v; e.d = d; e.b = b; e.r = r; e.name = name;
    sb.push_back(e);
  endtask

  task automatic expect_rsp(input int port, input logic [DATA_W-1:0] d,
                            input bit b, input logic [ROB_W-1:0] r, input string name);
    push_exp(port, 1'b1, 1'b1, d, b, r, name);
  endtask

  task automatic expect_invalid(input int port, input string name);
    push_exp(port, 1'b0, 1'b0, '0, 1'b0, '0, name);
  endtask

  task automatic expect_zero(input int port, input string name);
    push_exp(port, 1'b1, 1'b0, '0, 1'b0, '0, name);
  endtask

  task automatic idle();
    alloc_valid = '0;
    wb_valid    = '0;
    flush       = 1'b0;
    rd_valid    = '0;
    rd_stall    = '0;
  endtask

  task automatic do_read(input int port, input int preg);
    rd_valid[port] = 1'b1;
    rd_preg[port]  = PREG_W'(preg);
  endtask

  task automatic do_alloc(input int port, input int preg, input int rob);
    alloc_valid[port] = 1'b1;
    alloc_preg[port]  = PREG_W'(preg);
    alloc_rob[port]   = ROB_W'(rob);
  endtask

  task automatic do_wb(input int port, input int preg, input logic [DATA_W-1:0] data);
    wb_valid[port] = 1'b1;
    wb_preg[port]  = PREG_W'(preg);
    wb_data[port]  = data;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Monitor: after every edge, pop and compare the expectations for it
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      while (sb.size() > 0 && sb[0].tgt <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (e.tgt < cyc) begin
          errors++;
          $display("FAIL %s port%0d: expectation for cycle %0d not checked (now %0d)",
                   e.name, e.port, e.tgt, cyc);
        end else if ((rsp_valid[e.port] !== e.v) ||
                     (e.chk_all && ((rsp_data[e.port] !== e.d) ||
                                    (rsp_busy[e.port] !== e.b) ||
                                    (rsp_rob[e.port]  !== e.r)))) begin
          errors++;
          $display("FAIL %s port%0d: got v=%0b d=%h busy=%0b rob=%0d, expected v=%0b d=%h busy=%0b rob=%0d%s",
                   e.name, e.port, rsp_valid[e.port], rsp_data[e.port], rsp_busy[e.port],
                   rsp_rob[e.port], e.v, e.d, e.b, e.r, e.chk_all ? "" : " (valid only)");
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete (errors=%0d)", errors);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    alloc_preg = '0; alloc_rob = '0; wb_preg = '0; wb_data = '0; rd_preg = '0;
    idle();
    step();

    // Reset wins over a pending read
    do_read(0, 5);
    for (int p = 0; p < N_RD; p++) expect_zero(p, "reset_state");
    step();

    rst = 1'b0;
    idle(); do_read(0, 5);
    expect_rsp(0, 32'h0, 1'b0, 5'd0, "rd_p5_after_reset");
    step();

    idle(); do_wb(0, 0, 32'hDEAD); do_read(1, 0);
    expect_rsp(1, 32'h0, 1'b0, 5'd0, "rd_p0_same_cycle_wb");
    step();

    idle(); do_read(1, 0);
    expect_rsp(1, 32'h0, 1'b0, 5'd0, "rd_p0_after_wb");
    expect_invalid(0, "p0_valid_drop");
    step();

    // Allocation then writeback forwarding
    idle(); do_alloc(0, 9, 3); step();
    idle(); do_read(0, 9);
    expect_rsp(0, 32'h0, 1'b1, 5'd3, "rd_p9_busy");
    step();
    idle(); do_wb(1, 9, 32'h1234); do_read(0, 9);
    expect_rsp(0, BYP ? 32'h1234 : 32'h0, BYP ? 1'b0 : 1'b1, 5'd3, "rd_p9_wb_fwd");
    step();
    idle(); do_read(0, 9);
    expect_rsp(0, 32'h1234, 1'b0, 5'd3, "rd_p9_after_wb");
    step();

    // Stall-hold with a writeback to the held preg
    idle(); do_alloc(1, 12, 7); step();
    idle(); do_read(2, 12);
    expect_rsp(2, 32'h0, 1'b1, 5'd7, "rd_p12_busy");
    step();
    idle(); rd_stall[2] = 1'b1; do_read(2, 5); do_wb(0, 12, 32'hABCD);
    expect_rsp(2, BYP ? 32'hABCD : 32'h0, BYP ? 1'b0 : 1'b1, 5'd7, "held_p12_wb");
    step();
    idle(); rd_stall[2] = 1'b1; do_read(2, 5);
    expect_rsp(2, BYP ? 32'hABCD : 32'h0, BYP ? 1'b0 : 1'b1, 5'd7, "held_p12_hold");
    step();
    idle(); do_read(2, 12);
    expect_rsp(2, 32'hABCD, 1'b0, 5'd7, "rd_p12_after_stall");
    step();

    // Same-cycle conflicts
    idle(); do_wb(0, 7, 32'h11); do_wb(1, 7, 32'h22); step();
    idle(); do_read(3, 7);
    expect_rsp(3, 32'h11, 1'b0, 5'd0, "wb_conflict_p7");
    do_wb(0, 8, 32'h55); do_alloc(0, 8, 9); do_alloc(1, 8, 10);
    step();
    idle(); do_read(4, 8);
    expect_rsp(4, 32'h55, 1'b1, 5'd9, "alloc_wb_p8");
    step();

    // Flush
    idle(); do_alloc(0, 20, 1); do_alloc(1, 21, 2); step();
    idle(); do_read(5, 20); do_read(0, 21);
    expect_rsp(5, 32'h0, 1'b1, 5'd1, "rd_p20_busy");
    expect_rsp(0, 32'h0, 1'b1, 5'd2, "rd_p21_busy");
    step();
    idle(); flush = 1'b1; rd_stall[5] = 1'b1; do_alloc(0, 22, 6);
    do_read(0, 21); do_read(1, 21);
    for (int p = 0; p < N_RD; p++) expect_invalid(p, "flush_valid");
    step();
    idle(); do_read(0, 20); do_read(1, 21); do_read(2, 22);
    expect_rsp(0, 32'h0, 1'b0, 5'd1, "rd_p20_post_flush");
    expect_rsp(1, 32'h0, 1'b0, 5'd2, "rd_p21_post_flush");
    expect_rsp(2, 32'h0, 1'b0, 5'd0, "rd_p22_post_flush");
    step();

    // Reset while busy and holding a response
    idle(); do_alloc(0, 30, 4); step();
    idle(); do_read(3, 30);
    expect_rsp(3, 32'h0, 1'b1, 5'd4, "rd_p30_busy");
    step();
    idle(); rd_stall[3] = 1'b1;
    expect_rsp(3, 32'h0, 1'b1, 5'd4, "held_p30");
    step();
    idle(); rst = 1'b1; rd_stall[3] = 1'b1; do_read(4, 9);
    for (int p = 0; p < N_RD; p++) expect_zero(p, "reset_mid_run");
    step();
    rst = 1'b0;
    idle(); do_read(3, 30); do_read(0, 9); do_read(1, 12); do_read(2, 8);
    expect_rsp(3, 32'h0, 1'b0, 5'd0, "rd_p30_after_rst");
    expect_rsp(0, 32'h0, 1'b0, 5'd0, "rd_p9_after_rst");
    expect_rsp(1, 32'h0, 1'b0, 5'd0, "rd_p12_after_rst");
    expect_rsp(2, 32'h0, 1'b0, 5'd0, "rd_p8_after_rst");
    step();

    idle(); step(); step();

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
